pixel_frame_writer: RTL and testbench

Sink-side counterpart of the image top module's eight-pixel neighbourhood output bus (out1..out8). Accepts one 8-byte pixel bundle per valid/ready handshake and serialises it into a byte-wide result frame memory at consecutive addresses. It counts bundles per frame and pulses `done` when the frame is fully written. It sits between the processing top and the result RAM or readback path.

---
 rtl/pixel_frame_writer_if.sv | 31 +++
 rtl/pixel_frame_writer.sv | 128 ++++++++++++
 tb/tb_pixel_frame_writer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_frame_writer_if.sv
// Bundle-in / byte-out bus for pixel_frame_writer: 8-byte bundle stream with
// valid/ready handshake plus the byte-wide frame-memory write port.
interface pixel_frame_writer_if #(
  parameter int ADDR_W = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in1;
  logic [7:0]        in2;
  logic [7:0]        in3;
  logic [7:0]        in4;
  logic [7:0]        in5;
  logic [7:0]        in6;
  logic [7:0]        in7;
  logic [7:0]        in8;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  // Producer of bundles / observer of the memory port
  modport master (
    output in_valid, in1, in2, in3, in4, in5, in6, in7, in8,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // The frame writer itself
  modport slave (
    input  in_valid, in1, in2, in3, in4, in5, in6, in7, in8,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pixel_frame_writer.sv
// Serialises 8-byte pixel bundles into a byte-wide frame memory, BUNDLES per frame.
// Optional running byte checksum output when PIXEL_FRAME_WRITER_CHKSUM_EN is defined.
module pixel_frame_writer #(
  parameter int BUNDLES = 64,
  parameter int ADDR_W  = 9
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  pixel_frame_writer_if.slave  bus,
  output logic                 busy,
  output logic                 done
`ifdef PIXEL_FRAME_WRITER_CHKSUM_EN
  ,
  output logic [15:0]          chksum
`endif
);

  localparam int CNT_W = $clog2(BUNDLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BUNDLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [2:0]        idx;
  logic [2:0]        nxt;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        hold [8];
  logic [ADDR_W-1:0] base;
  logic              accept;

  assign accept = (state == S_WAIT) && bus.in_valid && bus.in_ready;
  assign base   = ADDR_W'(cnt) << 3;
  assign nxt    = idx + 3'd1;

  // Holding register: data only, loaded on the accept edge, never reset
  always_ff @(posedge CLK) begin
    if (accept) begin
      hold[0] <= bus.in1;
      hold[1] <= bus.in2;
      hold[2] <= bus.in3;
      hold[3] <= bus.in4;
      hold[4] <= bus.in5;
      hold[5] <= bus.in6;
      hold[6] <= bus.in7;
      hold[7] <= bus.in8;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= S_IDLE;
      idx           <= 3'd0;
      cnt           <= '0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.mem_we <= 1'b0;
          done       <= 1'b0;
          if (start) begin
            state        <= S_WAIT;
            busy         <= 1'b1;
            bus.in_ready <= 1'b1;
            cnt          <= '0;
            idx          <= 3'd0;
          end
        end
        S_WAIT: begin
          // Byte 0 goes straight from in1 so the first write lands one cycle after accept
          if (accept) begin
            state         <= S_DRAIN;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= base;
            bus.mem_wdata <= bus.in1;
            idx           <= 3'd0;
          end
        end
        S_DRAIN: begin
          if (idx == 3'd7) begin
            bus.mem_we <= 1'b0;
            cnt        <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state        <= S_WAIT;
              bus.in_ready <= 1'b1;
            end
          end else begin
            idx           <= nxt;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= base + ADDR_W'(nxt);
            bus.mem_wdata <= hold[nxt];
          end
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PIXEL_FRAME_WRITER_CHKSUM_EN
  // Accumulates the byte on the bus each write cycle, so the last byte is in by the done cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      chksum <= 16'd0;
    end else if (state == S_IDLE && start) begin
      chksum <= 16'd0;
    end else if (bus.mem_we) begin
      chksum <= chksum + {8'd0, bus.mem_wdata};
    end
  end
`endif

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed self-checking bench for pixel_frame_writer (BUNDLES=1 and BUNDLES=4 instances).
module tb_pixel_frame_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0;
  logic start4 = 1'b0;
  logic busy1, done1, busy4, done4;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_frame_writer_if #(.ADDR_W(3)) if1 ();
  pixel_frame_writer_if #(.ADDR_W(5)) if4 ();

`ifdef PIXEL_FRAME_WRITER_CHKSUM_EN
  logic start2 = 1'b0;
  logic busy2, done2;
  logic [15:0] chk1, chk2, chk4;
  pixel_frame_writer_if #(.ADDR_W(4)) if2 ();
  pixel_frame_writer #(.BUNDLES(2), .ADDR_W(4)) u2 (
    .CLK(clk), .RST(rst), .start(start2), .bus(if2.slave),
    .busy(busy2), .done(done2), .chksum(chk2));
`endif

  pixel_frame_writer #(.BUNDLES(1), .ADDR_W(3)) u1 (
    .CLK(clk), .RST(rst), .start(start1), .bus(if1.slave),
    .busy(busy1), .done(done1)
`ifdef PIXEL_FRAME_WRITER_CHKSUM_EN
    , .chksum(chk1)
`endif
  );

  pixel_frame_writer #(.BUNDLES(4), .ADDR_W(5)) u4 (
    .CLK(clk), .RST(rst), .start(start4), .bus(if4.slave),
    .busy(busy4), .done(done4)
`ifdef PIXEL_FRAME_WRITER_CHKSUM_EN
    , .chksum(chk4)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic [7:0] b);
    if1.in1 = b;         if1.in2 = b + 8'd1; if1.in3 = b + 8'd2; if1.in4 = b + 8'd3;
    if1.in5 = b + 8'd4;  if1.in6 = b + 8'd5; if1.in7 = b + 8'd6; if1.in8 = b + 8'd7;
  endtask

  task automatic drive4(input logic [7:0] b);
    if4.in1 = b;         if4.in2 = b + 8'd1; if4.in3 = b + 8'd2; if4.in4 = b + 8'd3;
    if4.in5 = b + 8'd4;  if4.in6 = b + 8'd5; if4.in7 = b + 8'd6; if4.in8 = b + 8'd7;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    start4 = 1'b0;
    if4.in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", if4.in_ready); end
    checks++; if (if4.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", if4.mem_we); end
    checks++; if (if4.mem_addr !== 5'd0) begin errors++; $display("FAIL reset_mem_addr got %0d want 0", if4.mem_addr); end
    checks++; if (if4.mem_wdata !== 8'd0) begin errors++; $display("FAIL reset_mem_wdata got %h want 00", if4.mem_wdata); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done4); end
    checks++; if (if1.mem_we !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_u1 got we=%b busy=%b want 0 0", if1.mem_we, busy1); end
    rst = 1'b0;
    tick();
    checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got %b want 0", if4.in_ready); end
  endtask

  task automatic test_single;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL single_busy_start got %b want 1", busy1); end
    checks++; if (if1.in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", if1.in_ready); end
    if1.in_valid = 1'b1;
    drive1(8'h10);
    tick();
    if1.in_valid = 1'b0;
    drive1(8'hAA);
    for (int k = 0; k < 8; k++) begin
      checks++; if (if1.mem_we !== 1'b1) begin errors++; $display("FAIL single_we[%0d] got %b want 1", k, if1.mem_we); end
      checks++; if (if1.mem_addr !== 3'(k)) begin errors++; $display("FAIL single_addr[%0d] got %0d want %0d", k, if1.mem_addr, k); end
      checks++; if (if1.mem_wdata !== 8'(8'h10 + k)) begin errors++; $display("FAIL single_data[%0d] got %h want %h", k, if1.mem_wdata, 8'(8'h10 + k)); end
      checks++; if (if1.in_ready !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL single_drain_ctl[%0d] got ready=%b busy=%b want 0 1", k, if1.in_ready, busy1); end
      tick();
    end
    checks++; if (if1.mem_we !== 1'b0) begin errors++; $display("FAIL single_we_after got %b want 0", if1.mem_we); end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", done1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %b want 0", busy1); end
    tick();
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b want 0", done1); end
    checks++; if (if1.mem_addr !== 3'd7 || if1.mem_wdata !== 8'h17) begin errors++; $display("FAIL single_hold got addr=%0d data=%h want 7 17", if1.mem_addr, if1.mem_wdata); end
  endtask

  task automatic test_back_to_back;
    int nw = 0, nrdy = 0, ndone = 0, b = 0;
    int last_rdy = -1, last_we = -1, done_cyc = -1;
    bit acc;
    do_reset();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    if4.in_valid = 1'b1;
    drive4(8'd0);
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (if4.mem_we === 1'b1) begin
        checks++; if (if4.mem_addr !== 5'(nw)) begin errors++; $display("FAIL b2b_addr[%0d] got %0d want %0d", nw, if4.mem_addr, nw); end
        checks++; if (if4.mem_wdata !== 8'(nw)) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", nw, if4.mem_wdata, 8'(nw)); end
        nw++;
        last_we = cyc;
      end
      acc = (if4.in_ready === 1'b1);
      if (acc) begin
        if (last_rdy >= 0) begin
          checks++; if (cyc - last_rdy != 9) begin errors++; $display("FAIL b2b_ready_period got %0d want 9", cyc - last_rdy); end
        end
        last_rdy = cyc;
        nrdy++;
      end
      if (done4 === 1'b1) begin
        ndone++;
        done_cyc = cyc;
      end
      tick();
      if (acc) begin
        b++;
        drive4(8'(b * 8));
      end
    end
    if4.in_valid = 1'b0;
    checks++; if (nw != 32) begin errors++; $display("FAIL b2b_writes got %0d want 32", nw); end
    checks++; if (nrdy != 4) begin errors++; $display("FAIL b2b_ready_cycles got %0d want 4", nrdy); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL b2b_done_count got %0d want 1", ndone); end
    checks++; if (done_cyc != last_we + 1) begin errors++; $display("FAIL b2b_done_timing got cycle %0d want %0d", done_cyc, last_we + 1); end
  endtask

  task automatic test_stall;
    do_reset();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    if4.in_valid = 1'b1;
    drive4(8'h20);
    tick();
    if4.in_valid = 1'b0;
    drive4(8'h00);
    for (int k = 0; k < 8; k++) begin
      checks++; if (if4.mem_we !== 1'b1 || if4.mem_addr !== 5'(k) || if4.mem_wdata !== 8'(8'h20 + k)) begin
        errors++; $display("FAIL stall_first[%0d] got we=%b addr=%0d data=%h want 1 %0d %h", k, if4.mem_we, if4.mem_addr, if4.mem_wdata, k, 8'(8'h20 + k)); end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      checks++; if (if4.mem_we !== 1'b0) begin errors++; $display("FAIL stall_we[%0d] got %b want 0", i, if4.mem_we); end
      checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready[%0d] got %b want 1", i, if4.in_ready); end
      tick();
    end
    if4.in_valid = 1'b1;
    drive4(8'h30);
    tick();
    if4.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (if4.mem_we !== 1'b1 || if4.mem_addr !== 5'(8 + k) || if4.mem_wdata !== 8'(8'h30 + k)) begin
        errors++; $display("FAIL stall_second[%0d] got we=%b addr=%0d data=%h want 1 %0d %h", k, if4.mem_we, if4.mem_addr, if4.mem_wdata, 8 + k, 8'(8'h30 + k)); end
      tick();
    end
    do_reset();
  endtask

  task automatic test_reset_drain;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    if4.in_valid = 1'b1;
    drive4(8'h40);
    tick();
    if4.in_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (if4.mem_we !== 1'b1 || if4.mem_addr !== 5'd3) begin errors++; $display("FAIL rstd_pre got we=%b addr=%0d want 1 3", if4.mem_we, if4.mem_addr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (if4.mem_we !== 1'b0) begin errors++; $display("FAIL rstd_we got %b want 0", if4.mem_we); end
    checks++; if (if4.mem_addr !== 5'd0 || if4.mem_wdata !== 8'd0) begin errors++; $display("FAIL rstd_bus got addr=%0d data=%h want 0 00", if4.mem_addr, if4.mem_wdata); end
    checks++; if (if4.in_ready !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL rstd_ctl got ready=%b busy=%b done=%b want 0 0 0", if4.in_ready, busy4, done4); end
    tick();
    checks++; if (if4.mem_we !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL rstd_idle got we=%b busy=%b want 0 0", if4.mem_we, busy4); end
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    if4.in_valid = 1'b1;
    drive4(8'h50);
    tick();
    if4.in_valid = 1'b0;
    checks++; if (if4.mem_we !== 1'b1 || if4.mem_addr !== 5'd0 || if4.mem_wdata !== 8'h50) begin
      errors++; $display("FAIL rstd_restart got we=%b addr=%0d data=%h want 1 0 50", if4.mem_we, if4.mem_addr, if4.mem_wdata); end
    do_reset();
  endtask

  task automatic test_start_ignored;
    int nw = 0, ndone = 0, b = 0;
    bit acc;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    if4.in_valid = 1'b1;
    drive4(8'h80);
    for (int cyc = 0; cyc < 45; cyc++) begin
      start4 = (cyc < 30) && (cyc % 4 == 0);
      if (if4.mem_we === 1'b1) begin
        checks++; if (if4.mem_addr !== 5'(nw) || if4.mem_wdata !== 8'(8'h80 + nw)) begin
          errors++; $display("FAIL sti_write[%0d] got addr=%0d data=%h want %0d %h", nw, if4.mem_addr, if4.mem_wdata, nw, 8'(8'h80 + nw)); end
        nw++;
      end
      if (done4 === 1'b1) ndone++;
      acc = (if4.in_ready === 1'b1);
      tick();
      if (acc) begin
        b++;
        drive4(8'(8'h80 + b * 8));
      end
    end
    start4 = 1'b0;
    if4.in_valid = 1'b0;
    checks++; if (nw != 32) begin errors++; $display("FAIL sti_writes got %0d want 32", nw); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL sti_done_count got %0d want 1", ndone); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL sti_busy_end got %b want 0", busy4); end
  endtask

`ifdef PIXEL_FRAME_WRITER_CHKSUM_EN
  task automatic test_chksum;
    bit got_done = 1'b0;
    checks++; if (chk2 !== 16'd0) begin errors++; $display("FAIL chk_reset got %h want 0000", chk2); end
    if2.in1 = 8'hFF; if2.in2 = 8'hFF; if2.in3 = 8'hFF; if2.in4 = 8'hFF;
    if2.in5 = 8'hFF; if2.in6 = 8'hFF; if2.in7 = 8'hFF; if2.in8 = 8'hFF;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    if2.in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
      if (done2 === 1'b1) begin
        got_done = 1'b1;
        checks++; if (chk2 !== 16'h0FF0) begin errors++; $display("FAIL chk_done got %h want 0ff0", chk2); end
      end else begin
        tick();
      end
    end
    if2.in_valid = 1'b0;
    checks++; if (!got_done) begin errors++; $display("FAIL chk_timeout got no done want done"); end
    tick();
    tick();
    checks++; if (chk2 !== 16'h0FF0) begin errors++; $display("FAIL chk_stable got %h want 0ff0", chk2); end
  endtask
`endif

  initial begin
    if1.in_valid = 1'b0;
    if4.in_valid = 1'b0;
    drive1(8'h00);
    drive4(8'h00);
`ifdef PIXEL_FRAME_WRITER_CHKSUM_EN
    if2.in_valid = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_drain();
    test_start_ignored();
`ifdef PIXEL_FRAME_WRITER_CHKSUM_EN
    test_chksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
